// File: rtl/regbank_pkg.sv
// Shared defaults, derived widths and packed port types for the scoreboarded register bank.
// Optional read-after-write forwarding is selected with REGBANK_SB_BYPASS_EN.
package regbank_pkg;

  localparam int NUMREGS_D   = 32;
  localparam int DATAWIDTH_D = 32;
  localparam int NUMRP_D     = 2;
  localparam int NUMWP_D     = 2;

  localparam int ADDR_W = $clog2(NUMREGS_D);
  localparam int CNT_W  = $clog2(NUMREGS_D + 1);

  typedef logic [ADDR_W-1:0]                     addr_t;
  typedef logic [DATAWIDTH_D-1:0]                data_t;
  typedef logic [CNT_W-1:0]                      cnt_t;
  typedef logic [NUMRP_D-1:0][ADDR_W-1:0]        raddr_t;
  typedef logic [NUMRP_D-1:0][DATAWIDTH_D-1:0]   rdata_t;
  typedef logic [NUMWP_D-1:0][ADDR_W-1:0]        waddr_t;
  typedef logic [NUMWP_D-1:0][DATAWIDTH_D-1:0]   wdata_t;

endpackage

// File: rtl/regbank_sb_scoreboard.sv
// Pending-producer bits with alloc-over-write priority and a registered popcount.
// Register 0 is never marked busy, so the count tops out at NUMREGS-1.
module regbank_sb_scoreboard
  import regbank_pkg::*;
#(
  parameter int NUMREGS = NUMREGS_D,
  parameter int NUMWP   = NUMWP_D,
  localparam int AW     = $clog2(NUMREGS),
  localparam int CW     = $clog2(NUMREGS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUMWP-1:0]          we,
  input  logic [NUMWP-1:0][AW-1:0]  waddr,
  input  logic                      alloc,
  input  logic [AW-1:0]             alloc_addr,
  output logic [NUMREGS-1:0]        busy,
  output logic [CW-1:0]             busy_cnt
);

  logic [NUMREGS-1:0] busy_next;
  logic [CW-1:0]      cnt_next;

  // Writes retire producers first; an alloc in the same cycle then re-arms the bit.
  always_comb begin
    busy_next = busy;
    for (int w = 0; w < NUMWP; w++) begin
      if (we[w] && waddr[w] != '0) busy_next[waddr[w]] = 1'b0;
    end
    if (alloc && alloc_addr != '0) busy_next[alloc_addr] = 1'b1;
    busy_next[0] = 1'b0;
    cnt_next = '0;
    for (int i = 0; i < NUMREGS; i++) begin
      cnt_next = cnt_next + CW'(busy_next[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/regbank_sb.sv
// Multi-ported register bank (x0 hardwired to zero) with a pending-producer scoreboard.
// Define REGBANK_SB_BYPASS_EN to forward same-cycle write data to the read ports.
module regbank_sb
  import regbank_pkg::*;
#(
  parameter int NUMREGS   = NUMREGS_D,
  parameter int DATAWIDTH = DATAWIDTH_D,
  parameter int NUMRP     = NUMRP_D,
  parameter int NUMWP     = NUMWP_D,
  localparam int AW       = $clog2(NUMREGS),
  localparam int CW       = $clog2(NUMREGS + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUMRP-1:0]                re_i,
  input  logic [NUMRP-1:0][AW-1:0]        raddr_i,
  output logic [NUMRP-1:0][DATAWIDTH-1:0] rdata_o,
  output logic [NUMRP-1:0]                rbusy_o,
  input  logic [NUMWP-1:0]                we_i,
  input  logic [NUMWP-1:0][AW-1:0]        waddr_i,
  input  logic [NUMWP-1:0][DATAWIDTH-1:0] wdata_i,
  input  logic                            alloc_i,
  input  logic [AW-1:0]                   alloc_addr_i,
  output logic [CW-1:0]                   busy_cnt_o,
  output logic                            werr_o,
  input  logic                            clr_err_i
);

  logic [DATAWIDTH-1:0] regs [NUMREGS];
  logic [NUMREGS-1:0]   busy;
  logic                 collide;

  regbank_sb_scoreboard #(
    .NUMREGS (NUMREGS),
    .NUMWP   (NUMWP)
  ) u_scoreboard (
    .clk        (clk_i),
    .rst        (rst_i),
    .we         (we_i),
    .waddr      (waddr_i),
    .alloc      (alloc_i),
    .alloc_addr (alloc_addr_i),
    .busy       (busy),
    .busy_cnt   (busy_cnt_o)
  );

  // Ascending port order makes the higher-indexed port win on a shared address.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUMREGS; i++) regs[i] <= '0;
    end else begin
      for (int w = 0; w < NUMWP; w++) begin
        if (we_i[w] && waddr_i[w] != '0) regs[waddr_i[w]] <= wdata_i[w];
      end
    end
  end

  always_comb begin
    collide = 1'b0;
    for (int i = 0; i < NUMWP; i++) begin
      for (int j = i + 1; j < NUMWP; j++) begin
        if (we_i[i] && we_i[j] && waddr_i[i] == waddr_i[j] && waddr_i[i] != '0)
          collide = 1'b1;
      end
    end
  end

  // Set has priority over clear so a collision in the clearing cycle is not lost.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          werr_o <= 1'b0;
    else if (collide)   werr_o <= 1'b1;
    else if (clr_err_i) werr_o <= 1'b0;
  end

  always_comb begin
    for (int p = 0; p < NUMRP; p++) begin
      rdata_o[p] = '0;
      rbusy_o[p] = 1'b0;
      if (re_i[p] && !rst_i) begin
        rdata_o[p] = regs[raddr_i[p]];
        rbusy_o[p] = busy[raddr_i[p]];
`ifdef REGBANK_SB_BYPASS_EN
        begin
          logic hit;
          hit = 1'b0;
          for (int w = 0; w < NUMWP; w++) begin
            if (we_i[w] && waddr_i[w] != '0 && waddr_i[w] == raddr_i[p]) begin
              rdata_o[p] = wdata_i[w];
              hit        = 1'b1;
            end
          end
          // A forwarded value satisfies the reader unless a new producer issues now.
          if (hit) rbusy_o[p] = alloc_i && (alloc_addr_i == raddr_i[p]);
        end
`endif
      end
    end
  end

endmodule
